// File: rtl/load_store_unit.sv
// Load/store initiator: turns one core access into one or two word-aligned
// memory transfers and returns extended load data as a one-cycle response.
module load_store_unit #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
  state_t state;

  logic        l_we;
  logic [2:0]  l_ctrl;
  logic [1:0]  l_off;
  logic        l_split;
  logic [3:0]  l_be1;
  logic [31:0] l_wdata1;
  logic [31:0] lo;

  logic        legal;
  logic [3:0]  size_mask;
  logic [7:0]  mask8;
  logic [31:0] wmask;
  logic [63:0] wide;
  logic        split;

  // Lane decode is taken straight from the request so transfer 0 can be
  // registered on the accepting edge; transfer-1 fields are latched alongside.
  always_comb begin
    legal     = 1'b1;
    size_mask = '0;
    case (req_ctrl)
      3'b000, 3'b100: size_mask = 4'b0001;
      3'b001, 3'b101: size_mask = 4'b0011;
      3'b010:         size_mask = 4'b1111;
      default:        legal     = 1'b0;
    endcase
    mask8 = {4'b0000, size_mask} << req_addr[1:0];
    wmask = {{8{size_mask[3]}}, {8{size_mask[2]}}, {8{size_mask[1]}}, {8{size_mask[0]}}};
    wide  = {32'b0, req_wdata & wmask} << {req_addr[1:0], 3'b000};
    split = |mask8[7:4];
  end

  function automatic logic [31:0] extend(input logic [63:0] w, input logic [1:0] off,
                                         input logic [2:0] ctrl);
    logic [63:0] s;
    s = w >> {off, 3'b000};
    case (ctrl)
      3'b000:  extend = {{24{s[7]}}, s[7:0]};
      3'b001:  extend = {{16{s[15]}}, s[15:0]};
      3'b100:  extend = {24'b0, s[7:0]};
      3'b101:  extend = {16'b0, s[15:0]};
      default: extend = s[31:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      l_we      <= 1'b0;
      l_ctrl    <= '0;
      l_off     <= '0;
      l_split   <= 1'b0;
      l_be1     <= '0;
      l_wdata1  <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          l_we      <= req_we;
          l_ctrl    <= req_ctrl;
          l_off     <= req_addr[1:0];
          l_split   <= split;
          l_be1     <= mask8[7:4];
          l_wdata1  <= wide[63:32];
          if (!legal || (split && !MISALIGN_EN)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state     <= REQ0;
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= mask8[3:0];
            mem_wdata <= wide[31:0];
          end
        end
        REQ0: if (mem_gnt) begin
          mem_req <= 1'b0;
          state   <= WAIT0;
        end
        WAIT0: if (mem_rvalid) begin
          lo <= mem_rdata;
          if (l_split) begin
            state     <= REQ1;
            mem_req   <= 1'b1;
            mem_addr  <= mem_addr + 32'd4;
            mem_be    <= l_be1;
            mem_wdata <= l_wdata1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= l_we ? '0 : extend({32'b0, mem_rdata}, l_off, l_ctrl);
          end
        end
        REQ1: if (mem_gnt) begin
          mem_req <= 1'b0;
          state   <= WAIT1;
        end
        WAIT1: if (mem_rvalid) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= l_we ? '0 : extend({mem_rdata, lo}, l_off, l_ctrl);
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses checked
// against a byte-level reference model of the memory and response.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid0, req_valid1;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic [1:0]  rdy, rspv, rerr, mreq, mwe;
  logic [31:0] rdat [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [3:0]  mbe [2];

  always #5 clk = ~clk;

  load_store_unit #(.MISALIGN_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(rdy[0]),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv[0]), .rsp_rdata(rdat[0]), .rsp_err(rerr[0]),
    .mem_req(mreq[0]), .mem_gnt(mem_gnt), .mem_we(mwe[0]), .mem_addr(maddr[0]),
    .mem_be(mbe[0]), .mem_wdata(mwd[0]), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  load_store_unit #(.MISALIGN_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(rdy[1]),
    .req_we(req_we), .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rspv[1]), .rsp_rdata(rdat[1]), .rsp_err(rerr[1]),
    .mem_req(mreq[1]), .mem_gnt(mem_gnt), .mem_we(mwe[1]), .mem_addr(maddr[1]),
    .mem_be(mbe[1]), .mem_wdata(mwd[1]), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  bit [31:0] mem [bit [31:0]];

  // Observed transfers and response of the most recent operation.
  int          ntx;
  logic [31:0] t_addr [4];
  logic [3:0]  t_be [4];
  logic        t_we [4];
  logic [31:0] t_wd [4];
  logic        got;
  logic [31:0] r_data;
  logic        r_err;
  int          r_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] w);
    if (mem.exists(w)) return mem[w];
    return w ^ 32'h5A5AC3C3;
  endfunction

  task automatic run_op(input int sel, input logic we, input logic [2:0] ctrl,
                        input logic [31:0] addr, input logic [31:0] wdata, input int gw);
    int          n, e_ntx, stall, cyc;
    logic        legal, e_err, rv_pend;
    logic [31:0] e_addr [2];
    logic [3:0]  e_be [2];
    logic [31:0] e_wd [2];
    logic [31:0] e_data, a, w, rv_data;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    // Reference: walk the accessed bytes one at a time.
    legal = 1'b1;
    case (ctrl)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      3'b010:         n = 4;
      default: begin n = 0; legal = 1'b0; end
    endcase
    e_ntx = 0; e_data = '0;
    for (int i = 0; i < 2; i++) begin e_addr[i] = '0; e_be[i] = '0; e_wd[i] = '0; end
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      w = {a[31:2], 2'b00};
      if (e_ntx == 0 || e_addr[e_ntx-1] != w) begin e_addr[e_ntx] = w; e_ntx++; end
      e_be[e_ntx-1][a[1:0]] = 1'b1;
      e_wd[e_ntx-1][{a[1:0], 3'b000} +: 8] = wdata[8*i +: 8];
      e_data[8*i +: 8] = memrd(w) >> {a[1:0], 3'b000};
    end
    if (legal && n < 4 && !ctrl[2] && e_data[8*n-1]) e_data = e_data | ~((32'd1 << (8*n)) - 1);
    e_err = !legal || (e_ntx == 2 && sel == 1);
    if (e_err) e_ntx = 0;
    if (e_err || we) e_data = '0;

    @(negedge clk);
    req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    if (sel == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
    chk("req_ready_idle", rdy[sel], 1);
    @(posedge clk);
    #1 req_valid0 = 1'b0; req_valid1 = 1'b0;
    cyc = 1; ntx = 0; stall = 0; rv_pend = 0; got = 0; rv_data = '0;
    cap_addr = '0; cap_wd = '0; cap_be = '0; cap_we = 0;
    while (!got && cyc < 60 && ntx < 4) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rv_pend) begin
        chk("mem_req_low_in_wait", mreq[sel], 0);
        mem_rvalid = 1'b1; mem_rdata = rv_data; rv_pend = 0;
      end else if (mreq[sel]) begin
        if (stall == 0) begin
          cap_addr = maddr[sel]; cap_be = mbe[sel]; cap_wd = mwd[sel]; cap_we = mwe[sel];
        end else begin
          chk("stall_addr", maddr[sel], cap_addr);
          chk("stall_be", mbe[sel], cap_be);
          chk("stall_wdata", mwd[sel], cap_wd);
          chk("stall_we", mwe[sel], cap_we);
        end
        if (stall < gw) stall++;
        else begin
          mem_gnt = 1'b1;
          t_addr[ntx] = maddr[sel]; t_be[ntx] = mbe[sel];
          t_we[ntx] = mwe[sel]; t_wd[ntx] = mwd[sel];
          rv_data = memrd(maddr[sel]); rv_pend = 1; ntx++; stall = 0;
        end
      end
      if (rspv[sel]) begin
        got = 1; r_data = rdat[sel]; r_err = rerr[sel]; r_lat = cyc;
      end else begin
        @(posedge clk); cyc++;
      end
    end
    chk("response_seen", got, 1);
    chk("transfer_count", ntx, e_ntx);
    for (int t = 0; t < e_ntx && t < ntx; t++) begin
      chk("xfer_addr", t_addr[t], e_addr[t]);
      chk("xfer_be", t_be[t], e_be[t]);
      chk("xfer_we", t_we[t], we);
      if (we) chk("xfer_wdata", t_wd[t], e_wd[t]);
    end
    if (got) begin
      chk("rsp_rdata", r_data, e_data);
      chk("rsp_err", r_err, e_err);
      chk("rsp_latency", r_lat, e_err ? 1 : 1 + e_ntx * (2 + gw));
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("rsp_one_cycle", rspv[sel], 0);
      chk("ready_after_resp", rdy[sel], 1);
    end
    if (we && !e_err) begin
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        w = {a[31:2], 2'b00};
        mem[w] = memrd(w);
        mem[w][{a[1:0], 3'b000} +: 8] = wdata[8*i +: 8];
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
    req_ctrl = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", rdy[0], 1);
    chk("rst_rsp_valid", rspv[0], 0);
    chk("rst_mem_req", mreq[0], 0);
    chk("rst_mem_addr", maddr[0], 0);
    chk("rst_mem_be", mbe[0], 0);
    chk("rst_rsp_rdata", rdat[0], 0);
    chk("rst_ready_nomis", rdy[1], 1);
    rst_n = 1'b1;

    mem[32'h100] = 32'h8899AABB;
    run_op(0, 0, 3'b010, 32'h100, 0, 0);
    chk("lw_data", r_data, 32'h8899AABB);
    chk("lw_addr", t_addr[0], 32'h100);
    chk("lw_be", t_be[0], 4'b1111);
    chk("lw_lat", r_lat, 3);

    mem[32'h200] = 32'h80112233;
    run_op(0, 0, 3'b000, 32'h203, 0, 0);
    chk("lb_data", r_data, 32'hFFFFFF80);
    chk("lb_be", t_be[0], 4'b1000);
    run_op(0, 0, 3'b100, 32'h203, 0, 0);
    chk("lbu_data", r_data, 32'h00000080);

    run_op(0, 1, 3'b010, 32'h102, 32'hDEADBEEF, 0);
    chk("sw_t0_addr", t_addr[0], 32'h100);
    chk("sw_t0_be", t_be[0], 4'b1100);
    chk("sw_t0_wd", t_wd[0], 32'hBEEF0000);
    chk("sw_t1_addr", t_addr[1], 32'h104);
    chk("sw_t1_be", t_be[1], 4'b0011);
    chk("sw_t1_wd", t_wd[1], 32'h0000DEAD);
    chk("sw_rdata", r_data, 0);
    chk("sw_lat", r_lat, 5);

    mem[32'h3FC] = 32'hAB000000; mem[32'h400] = 32'h000000CD;
    run_op(0, 0, 3'b001, 32'h3FF, 0, 0);
    chk("lh_split_data", r_data, 32'hFFFFCDAB);
    run_op(0, 0, 3'b101, 32'h3FF, 0, 0);
    chk("lhu_split_data", r_data, 32'h0000CDAB);

    run_op(0, 0, 3'b011, 32'h100, 0, 0);
    chk("illegal_err", r_err, 1);
    chk("illegal_lat", r_lat, 1);
    chk("illegal_no_xfer", ntx, 0);
    run_op(1, 0, 3'b010, 32'h101, 0, 0);
    chk("nomis_err", r_err, 1);
    chk("nomis_rdata", r_data, 0);

    run_op(0, 1, 3'b001, 32'h3FF, 32'h1234ABCD, 3);
    run_op(1, 0, 3'b000, 32'h3FF, 0, 1);
    run_op(0, 0, 3'b010, 32'hFFFFFFFE, 0, 0);

    // Reset while the first transfer is outstanding.
    @(negedge clk);
    req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h500; req_valid0 = 1'b1;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("abort_req_up", mreq[0], 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req", mreq[0], 0);
    chk("abort_ready", rdy[0], 1);
    chk("abort_rsp", rspv[0], 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("late_rvalid_rsp", rspv[0], 0);
      chk("late_rvalid_req", mreq[0], 0);
      chk("late_rvalid_ready", rdy[0], 1);
    end

    for (int k = 0; k < 60; k++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFFFFFC | $urandom_range(0, 3);
      else if ($urandom_range(0, 1) == 0) ra = {28'h0000060, ra[3:0]};
      run_op(($urandom_range(0, 4) == 0) ? 1 : 0, 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), ra, $urandom, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store initiator between the core's memory stage and the word-organized data memory port. Accepts one load or store per handshake, encoded with the same 3-bit access-control code the data memory uses. Generates word-aligned memory requests with byte enables, and splits word-crossing misaligned accesses into two transfers. For loads, reassembles, sign-extends or zero-extends the result and returns it to the core as a single-cycle response.

## Interface
Parameters:
- MISALIGN_EN, default 1: 1 = split word-crossing accesses into two transfers; 0 = flag them with rsp_err and issue no transfer.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  access code: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, taken from the low bytes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal ctrl, or misaligned access with MISALIGN_EN=0; valid with rsp_valid.
- mem_req  out  1  memory request; held until granted.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word address; bits [1:0] always 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  byte-lane-aligned write data.
- mem_rvalid  in  1  completion from memory (read data or write ack); arrives at least 1 cycle after mem_gnt.
- mem_rdata  in  32  read word, valid with mem_rvalid.

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Handshake and latching:
  - A request is accepted when req_valid && req_ready.
  - The unit latches we, ctrl, addr and wdata; everything after that works from the latched copy.
- Size and offset:
  - Size n = 1 for B/BU, 2 for H/HU, 4 for W.
  - off = addr[1:0].
  - 8-bit mask = ((1<<n)-1) << off.
  - be0 = mask[3:0], be1 = mask[7:4].
  - Split when be1 != 0.
- Write data:
  - wide = {32'b0, wdata masked to n bytes} << (8*off).
  - Transfer 0 carries wide[31:0]; transfer 1 carries wide[63:32].
- Addresses:
  - Transfer 0 address = {addr[31:2], 2'b00}.
  - Transfer 1 address = transfer 0 address + 4, wrapping modulo 2^32.
- State transitions:
  - IDLE -> REQ0 on accept with legal ctrl.
  - IDLE -> RESP on accept with an illegal or unsupported access; rsp_err=1, no memory traffic.
  - REQ0 -> WAIT0 on mem_gnt.
  - WAIT0 -> REQ1 on mem_rvalid if split, else -> RESP.
  - REQ1 -> WAIT1 on mem_gnt.
  - WAIT1 -> RESP on mem_rvalid.
  - RESP -> IDLE unconditionally.
- Read assembly:
  - Capture mem_rdata into lo (WAIT0) and hi (WAIT1).
  - result = ({hi,lo} >> 8*off)[31:0], truncated to n bytes.
  - Sign-extend for B/H; zero-extend for BU/HU; unchanged for W.
- mem_rvalid outside WAIT0/WAIT1 is ignored.
- The memory side has at most one outstanding transfer.

## Timing
- Reset values:
  - req_ready = 1 after reset (IDLE).
  - All other outputs 0; state = IDLE.
  - Asserting rst_n low mid-operation aborts immediately: mem_req drops, and no rsp_valid is produced.
  - A late mem_rvalid after reset is ignored.
- Request/response timing:
  - mem_req rises the cycle after acceptance.
  - mem_we, mem_addr, mem_be and mem_wdata are stable while mem_req=1 && !mem_gnt.
  - mem_req is 0 in WAIT and RESP states.
  - rsp_valid is registered and asserted for exactly one cycle, in RESP.
- Minimum latencies (mem_gnt in the same cycle as mem_req, mem_rvalid 1 cycle later):
  - Aligned: accept at cycle 0, mem_req at cycle 1, mem_rvalid at cycle 2, rsp_valid at cycle 3.
  - Split: rsp_valid at cycle 5.
  - Error: rsp_valid at cycle 1.
- The next request is accepted in the cycle after RESP, when the unit is back in IDLE.

## Test plan
- Aligned LW:
  - Stimulus: addr 0x100; memory word 0x8899AABB.
  - Required: one transfer, mem_be=1111, mem_addr=0x100, rsp_rdata=0x8899AABB, rsp_valid at cycle 3.
- LB / LBU:
  - Stimulus: addr 0x203; mem_rdata 0x80112233.
  - Required: be=1000; LB returns 0xFFFFFF80; LBU returns 0x00000080.
- Misaligned SW:
  - Stimulus: addr 0x102, wdata 0xDEADBEEF.
  - Transfer 0: addr 0x100, be=1100, wdata 0xBEEF0000.
  - Transfer 1: addr 0x104, be=0011, wdata 0x0000DEAD.
  - Required: rsp_rdata=0.
- Misaligned LH:
  - Stimulus: addr 0x3FF; words 0xAB000000 @0x3FC and 0x000000CD @0x400.
  - Required: rsp_rdata=0xFFFFCDAB; LHU returns 0x0000CDAB.
- Errors:
  - ctrl=011 -> no mem_req; rsp_valid at cycle 1 with rsp_err=1, rsp_rdata=0.
  - With MISALIGN_EN=0, LW at 0x101 -> same response.
- Stalls and reset:
  - mem_gnt held low 3 cycles -> mem_* fields stable throughout.
  - rst_n pulsed low in WAIT0 -> state IDLE, mem_req=0, no rsp_valid.
  - A subsequent mem_rvalid is ignored.
